// File: rtl/rr_packet_arbiter_pkg.sv
// Shared constants for the round-robin packet arbiter:
//   clog2      - ceiling log2, used to size the grant index
//   arb_state_e - IDLE / LOCKED arbitration states
package rr_packet_arbiter_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_packet_arbiter_priority_pick.sv
// Rotating-priority picker (purely combinational).
//   cand : candidate request vector
//   ptr  : index of the highest-priority position
//   pick : one-hot selection of the first set candidate found scanning
//          ptr, ptr+1, ..., CHANNELS-1, 0, ... (all-zero when none set)
//   any  : at least one candidate is set
module rr_priority_pick #(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = 1
) (
    input  logic [CHANNELS-1:0] cand,
    input  logic [IDX_W-1:0]    ptr,
    output logic [CHANNELS-1:0] pick,
    output logic                any
);

    // Position reached after stepping 'off' places past p, wrapping modulo CHANNELS.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= CHANNELS) begin
            s = s - CHANNELS;
        end
        return s[IDX_W-1:0];
    endfunction

    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < CHANNELS; off++) begin
            if (!found && cand[wrap_idx(ptr, off)]) begin
                pick[wrap_idx(ptr, off)] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-locking arbiter. Produces the registered one-hot
// channel select for a downstream one-hot mux and holds a grant until the
// granted channel's last beat transfers.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   req_valid  - per-channel beat valid
//   req_last   - per-channel last-beat flag, qualified by req_valid
//   req_ready  - per-channel beat accept (only the granted channel)
//   onehot     - registered grant vector (zero or one-hot)
//   grant_idx  - binary index of the onehot bit, 0 when idle
//   o_valid    - beat valid toward the consumer
//   o_ready    - consumer accept
module rr_packet_arbiter
    import rr_packet_arbiter_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_valid,
    input  logic [CHANNELS-1:0] req_last,
    output logic [CHANNELS-1:0] req_ready,
    output logic [CHANNELS-1:0] onehot,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                o_valid,
    input  logic                o_ready
);

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [CHANNELS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CHANNELS-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;

    logic [CHANNELS-1:0] idle_pick, b2b_pick;
    logic                idle_any, b2b_any;
    logic [IDX_W-1:0]    ptr_next;
    logic                beat_xfer;
    logic                beat_last;

    // Outputs are AND terms of the registered grant with live inputs, so an
    // idle arbiter (onehot_q == 0) never raises o_valid or req_ready.
    assign onehot    = onehot_q;
    assign grant_idx = grant_idx_q;
    assign o_valid   = |(onehot_q & req_valid);
    assign req_ready = onehot_q & {CHANNELS{o_ready}};

    assign beat_xfer = o_valid && o_ready;
    assign beat_last = |(onehot_q & req_valid & req_last);

    // Position after the current grant; becomes the new ptr on packet end
    // and seeds the back-to-back search.
    assign ptr_next = (grant_idx_q == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    rr_priority_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_idle_pick (
        .cand (req_valid),
        .ptr  (ptr_q),
        .pick (idle_pick),
        .any  (idle_any)
    );

    // The finishing channel is masked so it must go back through IDLE.
    rr_priority_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_b2b_pick (
        .cand (req_valid & ~onehot_q),
        .ptr  (ptr_next),
        .pick (b2b_pick),
        .any  (b2b_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        onehot_d = onehot_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_any) begin
                    onehot_d = idle_pick;
                    state_d  = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Grant is held (even with req_valid low) until the last beat moves.
                if (beat_xfer && beat_last) begin
                    ptr_d = ptr_next;
                    if (b2b_any) begin
                        onehot_d = b2b_pick;
                    end else begin
                        onehot_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                onehot_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
        grant_idx_d = onehot_to_idx(onehot_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            onehot_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            onehot_q    <= onehot_d;
            grant_idx_q <= grant_idx_d;
        end
    end

endmodule
